des_key_schedule: RTL and testbench

Upstream stage of the DES datapath used by the tripledes top level. Takes one 56-bit key plus an encrypt/decrypt select and produces the 16 round subkeys (48 bits each), one per cycle, in round-application order. Uses a valid/ready handshake so the round engine can stall it. Three instances (key1, key2, key1), or one shared instance with three starts, supply each triple-DES pass.

---
 rtl/des_key_schedule_if.sv | 22 ++
 rtl/des_key_schedule.sv | 95 +++++++++
 tb/tb_des_key_schedule.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if: start/key request and subkey valid/ready stream of the DES key schedule.
interface des_key_schedule_if;
    logic        start;
    logic        e;
    logic [55:0] key;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        done;

    modport master (
        output start, e, key, subkey_ready,
        input  busy, subkey_valid, subkey, round, done
    );

    modport slave (
        input  start, e, key, subkey_ready,
        output busy, subkey_valid, subkey, round, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// des_key_schedule: issues the 16 DES round subkeys, one per valid/ready transfer, in encrypt or decrypt order.
module des_key_schedule (
    input  logic              clk,
    input  logic              rst_n,
    des_key_schedule_if.slave ks
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // bit i set when encrypt round i rotates by two instead of one
    localparam logic [15:0] two_shift = 16'h7efc;
    localparam logic [5:0] pc2_tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state, state_nxt;
    logic [27:0] c, d, c_nxt, d_nxt;
    logic [47:0] subkey;
    logic [3:0]  round, round_nxt, r_nxt;
    logic        mode, accept, last, load;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[47 - j] = cd[6'd56 - pc2_tab[j]];
        return y;
    endfunction

    assign accept = state == IDLE && ks.start;
    assign last   = round == 4'd15;
    assign r_nxt  = round + 4'd1;

    always_comb begin
        state_nxt       = state;
        c_nxt           = c;
        d_nxt           = d;
        round_nxt       = round;
        load            = 1'b0;
        ks.busy         = state == RUN;
        ks.subkey_valid = state == RUN;
        ks.done         = state == FIN;
        if (accept) begin
            state_nxt = RUN;
            c_nxt     = ks.e ? rotl(ks.key[55:28], 1'b0) : ks.key[55:28];
            d_nxt     = ks.e ? rotl(ks.key[27:0], 1'b0) : ks.key[27:0];
            round_nxt = '0;
            load      = 1'b1;
        end else if (state == RUN && ks.subkey_ready) begin
            // the decrypt step after the last subkey undoes the one-bit offset so C/D ends on the loaded key
            state_nxt = last ? FIN : RUN;
            c_nxt     = mode ? (last ? c : rotl(c, two_shift[r_nxt])) : rotr(c, two_shift[4'd0 - r_nxt]);
            d_nxt     = mode ? (last ? d : rotl(d, two_shift[r_nxt])) : rotr(d, two_shift[4'd0 - r_nxt]);
            round_nxt = r_nxt;
            load      = !last;
        end else if (state == FIN) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c      <= '0;
            d      <= '0;
            round  <= '0;
            mode   <= 1'b0;
            subkey <= '0;
        end else begin
            c     <= c_nxt;
            d     <= d_nxt;
            round <= round_nxt;
            if (accept) mode <= ks.e;
            if (load) subkey <= pc2({c_nxt, d_nxt});
        end
    end

    assign ks.subkey = subkey;
    assign ks.round  = round;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: randomized handshake bench for des_key_schedule against a cumulative-rotation DES key model.
module tb_des_key_schedule;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_key_schedule_if ks();
    des_key_schedule dut (.clk(clk), .rst_n(rst_n), .ks(ks));

    localparam logic [55:0] key0 = 56'hF0CCAAF556678F;
    localparam logic [47:0] k1_ref = 48'h1B02EFFC7072;
    localparam logic [47:0] k16_ref = 48'hCB3D8B0E17F5;

    int sh[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int pc2_t[48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    int checks = 0;
    int errors = 0;

    logic [47:0] got_key[16];
    int          got_round[16];
    logic [47:0] enc_seq[16];
    int n_xfer, stall_err, timeout, valid_cycles, cycles;
    int first_valid, first_round, done_fin, busy_fin, valid_fin, done_after;

    function automatic logic [27:0] rol(input logic [27:0] x, input int n);
        return n == 0 ? x : (x << n) | (x >> (28 - n));
    endfunction

    // Kn = PC-2 of each half rotated left by the total shift of rounds 1..n
    function automatic logic [47:0] ref_subkey(input logic [55:0] k, input int num);
        int cum;
        logic [55:0] cd;
        logic [47:0] y;
        cum = 0;
        for (int i = 0; i < num; i++) cum += sh[i];
        cd = {rol(k[55:28], cum % 28), rol(k[27:0], cum % 28)};
        for (int j = 0; j < 48; j++) y[47 - j] = cd[56 - pc2_t[j]];
        return y;
    endfunction

    function automatic logic [47:0] expect_at(input logic [55:0] k, input logic enc, input int i);
        return ref_subkey(k, enc ? i + 1 : 16 - i);
    endfunction

    task automatic run(input logic [55:0] k, input logic enc, input int ready_pct, input bit poke);
        bit stalled;
        logic [47:0] hold_k;
        logic [3:0] hold_r;
        stalled = 0;
        hold_k = '0;
        hold_r = '0;
        n_xfer = 0; stall_err = 0; timeout = 0; valid_cycles = 0; cycles = 0;
        ks.key = k;
        ks.e = enc;
        ks.start = 1'b1;
        ks.subkey_ready = 1'b0;
        @(posedge clk); #1;
        ks.start = 1'b0;
        first_valid = int'(ks.subkey_valid);
        first_round = int'(ks.round);
        while (n_xfer < 16) begin
            if (cycles > 400) begin
                timeout = 1;
                break;
            end
            cycles++;
            if (stalled && (!ks.subkey_valid || ks.subkey !== hold_k || ks.round !== hold_r)) stall_err++;
            if (poke) begin
                ks.start = 1'($urandom_range(1));
                ks.key = 56'({$urandom, $urandom});
                ks.e = 1'($urandom_range(1));
            end
            ks.subkey_ready = $urandom_range(99) < ready_pct;
            if (ks.subkey_valid) valid_cycles++;
            stalled = ks.subkey_valid && !ks.subkey_ready;
            hold_k = ks.subkey;
            hold_r = ks.round;
            if (ks.subkey_valid && ks.subkey_ready) begin
                got_key[n_xfer] = ks.subkey;
                got_round[n_xfer] = int'(ks.round);
                n_xfer++;
            end
            @(posedge clk); #1;
        end
        ks.start = 1'b0;
        ks.subkey_ready = 1'b0;
        done_fin = int'(ks.done);
        busy_fin = int'(ks.busy);
        valid_fin = int'(ks.subkey_valid);
        @(posedge clk); #1;
        done_after = int'(ks.done);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        ks.start = 1'b0; ks.e = 1'b0; ks.key = '0; ks.subkey_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ks.busy, ks.subkey_valid, ks.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {ks.busy, ks.subkey_valid, ks.done});
        end
        checks++;
        if (ks.round !== 4'd0 || ks.subkey !== 48'd0) begin
            errors++;
            $display("FAIL reset_data got round %0d subkey %h exp 0 0", ks.round, ks.subkey);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt;
        run(key0, 1'b1, 100, 1'b0);
        checks++;
        if (first_valid !== 1 || first_round !== 0) begin
            errors++;
            $display("FAIL enc_latency got valid %0d round %0d exp 1 0", first_valid, first_round);
        end
        checks++;
        if (got_key[0] !== k1_ref) begin
            errors++;
            $display("FAIL enc_k1 got %h exp %h", got_key[0], k1_ref);
        end
        checks++;
        if (got_key[15] !== k16_ref) begin
            errors++;
            $display("FAIL enc_k16 got %h exp %h", got_key[15], k16_ref);
        end
        for (int i = 0; i < 16; i++) begin
            enc_seq[i] = got_key[i];
            checks++;
            if (got_key[i] !== expect_at(key0, 1'b1, i) || got_round[i] !== i) begin
                errors++;
                $display("FAIL enc_seq[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_round[i], expect_at(key0, 1'b1, i), i);
            end
        end
        checks++;
        if (valid_cycles !== 16 || cycles !== 16 || timeout !== 0) begin
            errors++;
            $display("FAIL enc_stream got valid %0d cycles %0d exp 16 16", valid_cycles, cycles);
        end
        checks++;
        if (done_fin !== 1 || busy_fin !== 0 || valid_fin !== 0 || done_after !== 0) begin
            errors++;
            $display("FAIL enc_done got done %0d busy %0d valid %0d next_done %0d exp 1 0 0 0", done_fin, busy_fin, valid_fin, done_after);
        end
    endtask

    task automatic test_decrypt;
        run(key0, 1'b0, 100, 1'b0);
        checks++;
        if (got_key[0] !== k16_ref || got_key[15] !== k1_ref) begin
            errors++;
            $display("FAIL dec_ends got %h %h exp %h %h", got_key[0], got_key[15], k16_ref, k1_ref);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_key[i] !== enc_seq[15 - i] || got_key[i] !== expect_at(key0, 1'b0, i) || got_round[i] !== i) begin
                errors++;
                $display("FAIL dec_seq[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_round[i], expect_at(key0, 1'b0, i), i);
            end
        end
        checks++;
        if (done_fin !== 1 || done_after !== 0 || timeout !== 0) begin
            errors++;
            $display("FAIL dec_done got %0d then %0d exp 1 then 0", done_fin, done_after);
        end
    endtask

    task automatic test_backpressure;
        run(key0, 1'b1, 50, 1'b0);
        checks++;
        if (stall_err !== 0 || n_xfer !== 16 || timeout !== 0) begin
            errors++;
            $display("FAIL bp_stall got stall_err %0d xfers %0d exp 0 16", stall_err, n_xfer);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_key[i] !== enc_seq[i] || got_round[i] !== i) begin
                errors++;
                $display("FAIL bp_seq[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_round[i], enc_seq[i], i);
            end
        end
        checks++;
        if (done_fin !== 1) begin
            errors++;
            $display("FAIL bp_done got %0d exp 1", done_fin);
        end
    endtask

    task automatic test_ignore_start;
        logic [55:0] k2;
        run(key0, 1'b1, 70, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_key[i] !== enc_seq[i]) begin
                errors++;
                $display("FAIL busy_start_seq[%0d] got %h exp %h", i, got_key[i], enc_seq[i]);
            end
        end
        checks++;
        if (done_fin !== 1 || stall_err !== 0 || timeout !== 0) begin
            errors++;
            $display("FAIL busy_start_done got done %0d stall_err %0d exp 1 0", done_fin, stall_err);
        end
        k2 = 56'({$urandom, $urandom});
        run(k2, 1'b0, 100, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_key[i] !== expect_at(k2, 1'b0, i)) begin
                errors++;
                $display("FAIL restart_seq[%0d] got %h exp %h", i, got_key[i], expect_at(k2, 1'b0, i));
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int seen_done;
        n = 0;
        seen_done = 0;
        ks.key = key0; ks.e = 1'b1; ks.start = 1'b1; ks.subkey_ready = 1'b1;
        @(posedge clk); #1;
        ks.start = 1'b0;
        while (ks.round !== 4'd7 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ks.round !== 4'd7 || ks.subkey_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach got round %0d valid %b exp 7 1", ks.round, ks.subkey_valid);
        end
        checks++;
        if (ks.subkey !== expect_at(key0, 1'b1, 7)) begin
            errors++;
            $display("FAIL mid_k8 got %h exp %h", ks.subkey, expect_at(key0, 1'b1, 7));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ks.busy, ks.subkey_valid, ks.done} !== 3'b000 || ks.round !== 4'd0 || ks.subkey !== 48'd0) begin
            errors++;
            $display("FAIL mid_async got flags %b round %0d subkey %h exp 000 0 0", {ks.busy, ks.subkey_valid, ks.done}, ks.round, ks.subkey);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ks.subkey_ready = 1'b0;
        repeat (20) begin
            if (ks.done || ks.subkey_valid) seen_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL mid_no_done got %0d active cycles exp 0", seen_done);
        end
        run(key0, 1'b1, 100, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_key[i] !== enc_seq[i] || got_round[i] !== i) begin
                errors++;
                $display("FAIL mid_fresh[%0d] got %h/%0d exp %h/%0d", i, got_key[i], got_round[i], enc_seq[i], i);
            end
        end
    endtask

    task automatic test_extremes;
        logic [55:0] k;
        logic [47:0] want;
        int bad;
        for (int v = 0; v < 2; v++) begin
            for (int m = 0; m < 2; m++) begin
                k = v ? {56{1'b1}} : 56'd0;
                want = v ? {48{1'b1}} : 48'd0;
                run(k, 1'(m), 60, 1'b0);
                bad = 0;
                for (int i = 0; i < 16; i++) if (got_key[i] !== want) bad++;
                checks++;
                if (bad !== 0 || n_xfer !== 16) begin
                    errors++;
                    $display("FAIL extreme key %h e %0d got %0d wrong of %0d exp 0 wrong of 16", k, m, bad, n_xfer);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [55:0] k;
        logic enc;
        int bad;
        for (int t = 0; t < 8; t++) begin
            k = 56'({$urandom, $urandom});
            enc = 1'($urandom_range(1));
            run(k, enc, int'($urandom_range(100, 25)), 1'b0);
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (got_key[i] !== expect_at(k, enc, i) || got_round[i] !== i) bad++;
            checks++;
            if (bad !== 0 || stall_err !== 0 || done_fin !== 1 || timeout !== 0) begin
                errors++;
                $display("FAIL random key %h e %b got %0d wrong stall_err %0d done %0d exp 0 0 1", k, enc, bad, stall_err, done_fin);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_ignore_start();
        test_reset_mid();
        test_extremes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
